// File: rtl/bcd_conv_scheduler.sv
// Shared binary-to-BCD converter for the 7-segment path: round-robin between two
// requesters, one double-dabble iteration per clock, registered three-digit result.
module bcd_conv_scheduler #(
  parameter int WIDTH   = 32,
  parameter int MAX_VAL = 999
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             busy,
  output logic             done,
  output logic             src,
  output logic             overflow,
  output logic [3:0]       unidade,
  output logic [3:0]       dezena,
  output logic [3:0]       centena
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [11:0]      acc_reg, acc_next;        // {cent, dez, uni}
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             last_b_reg, last_b_next;  // 1 when B was granted last
  logic             ovf_pend_reg, ovf_pend_next;
  logic             id_reg, id_next;

  logic             ack_a_reg, ack_a_next;
  logic             ack_b_reg, ack_b_next;
  logic             done_reg, done_next;
  logic             src_reg, src_next;
  logic             overflow_reg, overflow_next;
  logic [11:0]      digits_reg, digits_next;

  logic [11:0]      acc_adj;
  logic [11:0]      acc_shifted;
  logic             grant_b;
  logic [WIDTH-1:0] grant_data;

  // Add-3 correction per digit, evaluated on the pre-shift accumulator.
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                (acc_reg[gi*4 +: 4] + 4'd3) : acc_reg[gi*4 +: 4];
  end

  // The bit leaving cent[3] falls off the top of the 12-bit shift.
  assign acc_shifted = (acc_adj << 1) | {11'd0, shift_reg[WIDTH-1]};

  assign grant_b    = req_b && (!req_a || !last_b_reg);
  assign grant_data = grant_b ? data_b : data_a;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    last_b_next   = last_b_reg;
    ovf_pend_next = ovf_pend_reg;
    id_next       = id_reg;
    ack_a_next    = 1'b0;
    ack_b_next    = 1'b0;
    done_next     = 1'b0;
    src_next      = src_reg;
    overflow_next = overflow_reg;
    digits_next   = digits_reg;

    case (state_reg)
      IDLE: begin
        if (req_a || req_b) begin
          shift_next    = grant_data;
          acc_next      = 12'd0;
          cnt_next      = CW'(WIDTH - 1);
          ovf_pend_next = (grant_data > MAX_V);
          id_next       = grant_b;
          last_b_next   = grant_b;
          ack_a_next    = !grant_b;
          ack_b_next    = grant_b;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        acc_next   = acc_shifted;
        shift_next = shift_reg << 1;
        cnt_next   = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          if (ovf_pend_reg) begin
            digits_next   = 12'hFFF;
            overflow_next = 1'b1;
          end else begin
            digits_next   = acc_shifted;
            overflow_next = 1'b0;
          end
          src_next   = id_reg;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      last_b_reg   <= 1'b1;
      ovf_pend_reg <= 1'b0;
      id_reg       <= 1'b0;
      ack_a_reg    <= 1'b0;
      ack_b_reg    <= 1'b0;
      done_reg     <= 1'b0;
      src_reg      <= 1'b0;
      overflow_reg <= 1'b0;
      digits_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      last_b_reg   <= last_b_next;
      ovf_pend_reg <= ovf_pend_next;
      id_reg       <= id_next;
      ack_a_reg    <= ack_a_next;
      ack_b_reg    <= ack_b_next;
      done_reg     <= done_next;
      src_reg      <= src_next;
      overflow_reg <= overflow_next;
      digits_reg   <= digits_next;
    end
  end

  assign busy     = (state_reg == SHIFT);
  assign ack_a    = ack_a_reg;
  assign ack_b    = ack_b_reg;
  assign done     = done_reg;
  assign src      = src_reg;
  assign overflow = overflow_reg;
  assign centena  = digits_reg[11:8];
  assign dezena   = digits_reg[7:4];
  assign unidade  = digits_reg[3:0];

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Sequential, shared binary-to-BCD conversion engine for the processor's 7-segment display path.
- Two requesters each submit a 32-bit value: A is the CPU output instruction, B is the OS/status monitor.
- The block arbitrates round-robin and runs the shift-and-add-3 (double dabble) algorithm one bit per clock.
- It returns three registered BCD digits (unidade, dezena, centena), an overflow flag and a done pulse tagged with the source.

Parameters:
- WIDTH, 32, operand width in bits (one conversion iteration per bit).
- MAX_VAL, 999, largest value representable in three digits; larger operands flag overflow.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_a  in  1  requester A asks for a conversion; held until ack_a.
- data_a  in  WIDTH  operand A; sampled only in the grant cycle.
- ack_a  out  1  one-cycle pulse: operand A captured.
- req_b  in  1  requester B asks for a conversion; held until ack_b.
- data_b  in  WIDTH  operand B; sampled only in the grant cycle.
- ack_b  out  1  one-cycle pulse: operand B captured.
- busy  out  1  high while a conversion is in progress (state SHIFT).
- done  out  1  one-cycle pulse: result outputs updated.
- src  out  1  source of the result currently on the outputs (0=A, 1=B).
- overflow  out  1  operand of the last result exceeded MAX_VAL.
- unidade  out  4  BCD units digit.
- dezena  out  4  BCD tens digit.
- centena  out  4  BCD hundreds digit.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; shift register, digit accumulators and bit counter clear.
  - ack_a, ack_b, busy, done, src, overflow, unidade, dezena and centena all go to 0.
  - The round-robin pointer is set so that A wins the first tie.
  - Reset mid-conversion aborts with no done pulse; the requester is not re-acked.
- States:
  - IDLE, SHIFT; busy = (state==SHIFT).
- IDLE, at an edge with any req high:
  - Grant one requester: A only, B only, or both. On a tie, grant the requester not granted last, then update the pointer.
  - Capture the granted operand into the shift register and clear the accumulators (cent, dez, uni).
  - Latch ovf_pending = (operand > MAX_VAL), an unsigned compare, and latch the source id.
  - Load the counter with WIDTH-1, pulse the matching ack for exactly the next cycle, and go to SHIFT.
- IDLE with no req:
  - Hold state; all outputs hold.
- SHIFT, each edge, one iteration:
  - First, each accumulator digit ≥5 gets +3, evaluated per digit on pre-shift values.
  - Then shift the 12-bit {cent,dez,uni} left by one, taking the MSB of the shift register in as the LSB; the shift register also shifts left.
  - The bit shifted out of cent[3] is discarded.
  - Decrement the counter.
- On the edge where counter==0:
  - Perform the final iteration and write the outputs:
    - If ovf_pending==0, unidade, dezena and centena take the post-iteration digits and overflow=0.
    - If ovf_pending==1, all three digits become 4'hF (display blank code) and overflow=1.
  - src takes the latched id, done pulses for one cycle, and state returns to IDLE.
- Latency:
  - Request sampled at edge E, so ack is high in the cycle after E.
  - done is high in the cycle after edge E+WIDTH, i.e. WIDTH cycles after ack (32 by default).
  - The next request can be accepted at edge E+WIDTH+1, so throughput is one conversion per WIDTH+1 cycles.
- Handshake rules:
  - req is ignored while in SHIFT.
  - A requester must drop req in its ack cycle. A req still high when the block returns to IDLE counts as a new request.
  - data is don't-care outside the grant edge.
  - A losing requester keeps req high and is served next.
- Result outputs hold their value between done pulses. done and ack are never high in the same cycle for the same transaction.

Test Plan:
- Reset, then req_a=1 with data_a=255:
  - ack_a pulses one cycle later.
  - done arrives 32 cycles after ack_a, with centena=2, dezena=5, unidade=5, src=0, overflow=0.
- data_b=0, then data_b=999 via B:
  - First result is digits 0,0,0.
  - Second result is 9,9,9 with src=1 and overflow=0.
- data_a=1000 and data_a=32'hFFFFFFFF:
  - Both give overflow=1 and all digits 4'hF.
  - The next request, data_a=7, gives 0,0,7 with overflow=0.
- req_a and req_b both high with data_a=123, data_b=456:
  - A is served first: ack_a, then done with 1,2,3, src=0.
  - B is served immediately after: ack_b at edge E+33, then 4,5,6, src=1.
  - Repeat the tie; B must lose this time.
- Assert reset=0 for one cycle at the 10th SHIFT cycle of data_a=500:
  - No done pulse; outputs read 0.
  - A re-request of 500 gives 5,0,0.
- Hold req_a high continuously:
  - One ack per conversion, acks exactly WIDTH+1 cycles apart.
  - A change of data_a between grants is not reflected in the current result.
